// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripherals: FSM encoding, default baud
// divisor and status-word bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // 50 MHz system clock, 115200 baud
  localparam int DEFAULT_BAUD_DIV = 434;

  localparam int DONE_BIT = 0;
  localparam int BUSY_BIT = 1;

  // Clock cycles occupied by one frame (start + payload + optional parity + stop).
  function automatic int frame_cycles(input int data_width, input int baud_div,
                                      input bit with_parity);
    return (data_width + 2 + (with_parity ? 1 : 0)) * baud_div;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-rate counter: counts 0..BAUD_DIV-1 and pulses tick on the last count.
// Shared between the UART TX and RX peripherals.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(BAUD_DIV - 1);

  logic [CNT_WIDTH-1:0] count;

  assign tick = (count == LAST_COUNT);

  // restart holds the counter at zero so every bit period starts aligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// Holding register written by stores; start strobe launches a frame on tx.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int CNT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        enable_StoreTxbuff,
  input  logic [31:0] wdata,
  input  logic        start_uart_tx,
  input  logic        clr_tx_flag,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done_flag,
  output logic [31:0] tx_status,
  output logic [2:0]  fsm_state
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_t           state, state_next;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]      bit_idx, bit_idx_next;
  logic                  tx_reg, tx_next;
  logic                  done_reg, done_next;
  logic                  launch, done_set;
  logic                  restart, tick;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg, parity_next;
`endif

  generate
    if (DATA_WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_bits;
      assign unused_wdata_bits = ^wdata[31:DATA_WIDTH];
    end
  endgenerate

  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Holding register accepts stores at any time; a frame in flight
  // transmits from shift_reg and is never affected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_reg <= '0;
    end else if (mem_write && enable_StoreTxbuff) begin
      hold_reg <= wdata[DATA_WIDTH-1:0];
    end
  end

  // start_uart_tx is a single-cycle strobe, honoured only in IDLE; strobes
  // while busy are dropped. The frame always uses the pre-write holding value.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx;
    launch       = 1'b0;
    done_set     = 1'b0;
    case (state)
      IDLE: begin
        if (start_uart_tx) begin
          state_next   = START;
          shift_next   = hold_reg;
          bit_idx_next = '0;
          launch       = 1'b1;
        end
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    restart = (state == IDLE) || (state_next != state);

    // Line level for the cycle after this edge, so tx comes straight off a flop
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_reg;
`endif
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase

    // A completing frame outranks a simultaneous clear
    if (done_set) begin
      done_next = 1'b1;
    end else if (launch || !clr_tx_flag) begin
      done_next = 1'b0;
    end else begin
      done_next = done_reg;
    end

`ifdef UART_TX_PARITY_EN
    parity_next = launch ? ^hold_reg : parity_reg;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_idx    <= bit_idx_next;
      tx_reg     <= tx_next;
      done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  assign tx           = tx_reg;
  assign tx_busy      = (state != IDLE);
  assign tx_done_flag = done_reg;
  assign fsm_state    = state;

  always_comb begin
    tx_status           = '0;
    tx_status[BUSY_BIT] = tx_busy;
    tx_status[DONE_BIT] = done_reg;
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph at BAUD_DIV=4: a frame-level model predicts tx, busy,
// done and status every cycle; directed tests pin the model with literal frames.
module tb_uart_tx_periph;

  localparam int DW = 8;
  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int F = FB * BD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic        enable_StoreTxbuff = 1'b0;
  logic [31:0] wdata = '0;
  logic        start_uart_tx = 1'b0;
  logic        clr_tx_flag = 1'b1;
  logic        tx;
  logic        tx_busy;
  logic        tx_done_flag;
  logic [31:0] tx_status;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uart_tx_periph #(
    .DATA_WIDTH(DW),
    .BAUD_DIV  (BD),
    .CNT_WIDTH (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_write         (mem_write),
    .enable_StoreTxbuff(enable_StoreTxbuff),
    .wdata             (wdata),
    .start_uart_tx     (start_uart_tx),
    .clr_tx_flag       (clr_tx_flag),
    .tx                (tx),
    .tx_busy           (tx_busy),
    .tx_done_flag      (tx_done_flag),
    .tx_status         (tx_status),
    .fsm_state         (fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // exp_q holds the line level for each upcoming cycle of the frame in flight.
  logic [0:0] exp_q[$];
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_hold = '0;
  bit         cmp_en = 1'b0;

  task automatic push_level(input logic lvl);
    for (int i = 0; i < BD; i++) exp_q.push_back(lvl);
  endtask

  always @(posedge clk or negedge reset) begin
    logic set_now;
    if (!reset) begin
      exp_q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_hold = '0;
    end else begin
      set_now = 1'b0;
      if (!m_busy && start_uart_tx) begin
        push_level(1'b0);
        for (int b = 0; b < DW; b++) push_level(m_hold[b]);
`ifdef UART_TX_PARITY_EN
        push_level(^m_hold);
`endif
        push_level(1'b1);
        m_done = 1'b0;
      end
      if (exp_q.size() > 0) begin
        m_tx   = exp_q.pop_front();
        m_busy = 1'b1;
      end else if (m_busy) begin
        m_busy  = 1'b0;
        m_tx    = 1'b1;
        m_done  = 1'b1;
        set_now = 1'b1;
      end
      if (!clr_tx_flag && !set_now) m_done = 1'b0;
      if (mem_write && enable_StoreTxbuff) m_hold = wdata[7:0];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_tx", {31'b0, tx}, {31'b0, m_tx});
      check("cyc_busy", {31'b0, tx_busy}, {31'b0, m_busy});
      check("cyc_done", {31'b0, tx_done_flag}, {31'b0, m_done});
      check("cyc_status", tx_status, {30'b0, m_busy, m_done});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    mem_write          = 1'b1;
    enable_StoreTxbuff = 1'b1;
    wdata              = $urandom();
    wdata[7:0]         = d;
    tick();
    mem_write          = 1'b0;
    enable_StoreTxbuff = 1'b0;
  endtask

  task automatic start();
    start_uart_tx = 1'b1;
    tick();
    start_uart_tx = 1'b0;
  endtask

  // Called right after start(): samples each bit mid-period over cycles 1..F+1.
  task automatic capture(output logic [10:0] bits, output int busy_cnt, output logic done_end);
    bits     = '0;
    busy_cnt = 0;
    done_end = 1'b0;
    for (int c = 1; c <= F + 1; c++) begin
      @(negedge clk);
      if (tx_busy) busy_cnt++;
      if (c <= F && ((c - 1) % BD) == BD / 2) bits[(c - 1) / BD] = tx;
      if (c == F + 1) done_end = tx_done_flag;
    end
  endtask

  // Expected frame for a payload with an even number of ones (parity bit 0).
  function automatic logic [10:0] frame_even(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, 1'b0, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [10:0] bits;
    int          busy_cnt;
    logic        done_end;

    #2 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_busy", {31'b0, tx_busy}, 32'h0);
    check("rst_done", {31'b0, tx_done_flag}, 32'h0);
    check("rst_status", tx_status, 32'h0);
    reset = 1'b1;
    tick();

    // 0x55 frame: alternating line levels, then done
    wr(8'h55);
    start();
    capture(bits, busy_cnt, done_end);
`ifndef UART_TX_PARITY_EN
    check("frame_55", {21'b0, bits[9:0]}, 32'h2AA);
`else
    check("frame_55", {21'b0, bits}, {21'b0, frame_even(8'h55)});
`endif
    check("busy_len_55", busy_cnt, F);
    check("done_55", {31'b0, done_end}, 32'h1);
    check("status_done", tx_status, 32'h1);

    // one-cycle clear pulse
    clr_tx_flag = 1'b0;
    tick();
    clr_tx_flag = 1'b1;
    @(negedge clk);
    check("clr_pulse", {31'b0, tx_done_flag}, 32'h0);
    tick();

    // clear held low across frame completion: set wins
    clr_tx_flag = 1'b0;
    start();
    repeat (F) tick();
    clr_tx_flag = 1'b1;
    @(negedge clk);
    check("set_wins", {31'b0, tx_done_flag}, 32'h1);
    tick();

    // start while busy is dropped; mid-frame write becomes next payload
    start();
    repeat (10) tick();
    start_uart_tx      = 1'b1;
    mem_write          = 1'b1;
    enable_StoreTxbuff = 1'b1;
    wdata              = 32'h0000_00A3;
    tick();
    start_uart_tx      = 1'b0;
    mem_write          = 1'b0;
    enable_StoreTxbuff = 1'b0;
    repeat (F) tick();
    @(negedge clk);
    check("no_requeue", {31'b0, tx_busy}, 32'h0);
    tick();
    start();
    capture(bits, busy_cnt, done_end);
    check("frame_a3", {21'b0, bits}, {21'b0, frame_even(8'hA3)});

    // same-cycle write and start, then back-to-back start in cycle F+1
    tick();
    wr(8'hF0);
    mem_write          = 1'b1;
    enable_StoreTxbuff = 1'b1;
    wdata              = 32'h1234_560F;
    start_uart_tx      = 1'b1;
    tick();
    mem_write          = 1'b0;
    enable_StoreTxbuff = 1'b0;
    start_uart_tx      = 1'b0;
    capture(bits, busy_cnt, done_end);
    check("frame_f0", {21'b0, bits}, {21'b0, frame_even(8'hF0)});
    start();
    capture(bits, busy_cnt, done_end);
    check("frame_0f", {21'b0, bits}, {21'b0, frame_even(8'h0F)});
    check("done_0f", {31'b0, done_end}, 32'h1);

    // store without the decoder select must not load the holding register
    tick();
    mem_write = 1'b1;
    wdata     = 32'h0000_00FF;
    tick();
    mem_write = 1'b0;

    // asynchronous reset mid-DATA
    wr(8'h3C);
    start();
    repeat (2 * BD + 1) tick();
    #2 reset = 1'b0;
    #1;
    check("arst_tx", {31'b0, tx}, 32'h1);
    check("arst_busy", {31'b0, tx_busy}, 32'h0);
    check("arst_done", {31'b0, tx_done_flag}, 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (30) tick();
    @(negedge clk);
    check("idle_after_rst", {31'b0, tx}, 32'h1);
    tick();
    start();
    capture(bits, busy_cnt, done_end);
    check("frame_zero", {21'b0, bits}, {21'b0, frame_even(8'h00)});

`ifdef UART_TX_PARITY_EN
    tick();
    wr(8'h07);
    start();
    capture(bits, busy_cnt, done_end);
    check("parity_bit", {31'b0, bits[9]}, 32'h1);
    check("frame_07", {21'b0, bits}, {21'b0, 11'b11_0000_0111_0});
    check("busy_len_07", busy_cnt, 44);
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected sequence end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter peripheral on the MIPS data bus. It is the responder to the data-memory address decoder. A store to the UART TX word loads a holding register. A write strobe from the decoder starts transmission of an 8N1 frame on `tx`. A sticky done flag, cleared by the decoder's active-low clear, reports completion back to software via load.

## Interface
Parameters:
- `DATA_WIDTH`, 8: number of payload bits per frame.
- `BAUD_DIV`, 434: clock cycles per bit (50 MHz / 115200). Legal values are at least 2.
- `CNT_WIDTH`, 16: width of the baud counter. Must satisfy 2^CNT_WIDTH > BAUD_DIV.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `mem_write`, in, 1: store instruction active this cycle.
- `enable_StoreTxbuff`, in, 1: decoder flag indicating the address selects the UART TX word.
- `wdata`, in, 32: store data. Bits [DATA_WIDTH-1:0] are captured.
- `start_uart_tx`, in, 1: active-high launch strobe from the decoder.
- `clr_tx_flag`, in, 1: active-low clear of the done flag, from the decoder.
- `tx`, out, 1: serial line. Idles high.
- `tx_busy`, out, 1: frame in progress.
- `tx_done_flag`, out, 1: sticky frame-complete flag.
- `tx_status`, out, 32: readback word `{30'b0, tx_busy, tx_done_flag}`.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `tx_done_flag`=0, holding register=0, shift register=0, counters=0, state=IDLE.
- Holding write: occurs when `mem_write && enable_StoreTxbuff`. Writes are accepted in any state and never disturb a frame in flight.
- Launch: when `start_uart_tx`=1 in IDLE, the current (pre-write) holding value is copied to the shift register. The FSM enters START, and `tx_done_flag` is cleared.
- A start strobe while busy is ignored. It is not queued.
- Same-cycle holding write and start: the frame uses the old holding value. The new value stays for the next frame.
- FSM:
  - IDLE: `tx`=1.
  - START: `tx`=0 for BAUD_DIV cycles.
  - DATA: DATA_WIDTH bits, LSB first, each held BAUD_DIV cycles. A bit index 0..DATA_WIDTH-1 runs, and the shift register shifts right per bit.
  - PARITY: present only with the macro defined.
  - STOP: `tx`=1 for BAUD_DIV cycles.
  - After STOP, return to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 and is reloaded to 0 on every state entry. A bit ends when count==BAUD_DIV-1.
- `tx_busy` = (state != IDLE). `tx` is driven from a register, so it is glitch-free.
- Done flag:
  - Set on the cycle STOP completes.
  - Cleared when `clr_tx_flag`=0 or on launch.
  - Simultaneous set and clear: set wins.
- Reset mid-frame: immediately returns to IDLE with `tx`=1. No partial stop bit is generated. The holding register is zeroed.

## Timing
- Frame length F = (DATA_WIDTH+2)·BAUD_DIV cycles, or (DATA_WIDTH+3)·BAUD_DIV cycles with parity.
- Start sampled high at edge 0:
  - `tx` falls and `tx_busy` rises after edge 0, i.e. visible in cycle 1.
  - Data bit k occupies cycles 1+(k+1)·BAUD_DIV through 1+(k+2)·BAUD_DIV-1.
  - `tx_busy` falls and `tx_done_flag` rises after edge F, both visible in cycle F+1.
- Back-to-back frames: a start in cycle F+1 is accepted. There is no mandatory idle gap beyond that one cycle.
- Holding-register write latency is 1 cycle. `tx_status` reflects flag changes 1 cycle after the causing edge.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the payload) for BAUD_DIV cycles. Frame is 11 bits.
- `UART_TX_PARITY_EN` undefined: no PARITY state or logic. Frame is 8N1, 10 bits.

## Structure
- Shared package `uart_pkg` holds:
  - the state enumeration (IDLE, START, DATA, PARITY, STOP) with a fixed 3-bit encoding;
  - the default BAUD_DIV constant;
  - the `tx_status` bit positions (DONE_BIT=0, BUSY_BIT=1).
- One sub-module, `baud_tick_gen`:
  - inputs: `clk`, `reset`, `restart`;
  - output: a `tick` at count==BAUD_DIV-1;
  - reused by the future UART RX peripheral.
- FSM, shift register and flag logic stay in the top module.

## Test plan
- Reset, then write 0x55 and start, with BAUD_DIV=4. `tx` must show 0,1,0,1,0,1,0,1,0,1, each level held exactly 4 cycles. Busy is high for 40 cycles, then done=1 and `tx_status`=0x1.
- Pulse `clr_tx_flag`=0 for one cycle after the done flag sets. Done must go to 0 next cycle. Hold clear low during the cycle STOP completes: done must still set.
- Start while busy, and write 0xA3 mid-frame. The frame in flight is unchanged and no second frame is sent. The next start transmits 0xA3.
- Same-cycle write of 0x0F and start with holding=0xF0. The frame carries 0xF0, and the next start sends 0x0F.
- Assert `reset` low mid-DATA. `tx`=1, busy=0 and done=0 immediately (asynchronously). The line stays idle after release.
- With `UART_TX_PARITY_EN`, send 0x07. The parity bit is 1 and the frame is 44 cycles at BAUD_DIV=4.
